// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if
// Bundles the two core-side snooping-bus ports and the memory port of the
// snoop_bus_arbiter.
//   master : the environment side (cores' L1 subsystems and memory). It drives
//            requests, issued operations, snoop responses and memory read data.
//   slave  : the arbiter side. It drives grants, snooped operations, response
//            data, hit status and the memory request.
// Per-core signals carry a 0/1 suffix. Operation encoding is
// BusRd=2'b00, BusUpgr=2'b01, BusRdX=2'b10, BusNoN=2'b11.
interface snoop_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_core0;
  logic              req_core1;
  logic              grant0;
  logic              grant1;
  logic [1:0]        bus_operation_out0;
  logic [1:0]        bus_operation_out1;
  logic [ADDR_W-1:0] bus_address_out0;
  logic [ADDR_W-1:0] bus_address_out1;
  logic [DATA_W-1:0] bus_data_out0;
  logic [DATA_W-1:0] bus_data_out1;
  logic              cache_hit_out0;
  logic              cache_hit_out1;
  logic              flush_out0;
  logic              flush_out1;
  logic [1:0]        bus_operation_in0;
  logic [1:0]        bus_operation_in1;
  logic [ADDR_W-1:0] bus_address_in0;
  logic [ADDR_W-1:0] bus_address_in1;
  logic [DATA_W-1:0] bus_data_in0;
  logic [DATA_W-1:0] bus_data_in1;
  logic              cache_hit_in0;
  logic              cache_hit_in1;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output req_core0, req_core1, bus_operation_out0, bus_operation_out1,
           bus_address_out0, bus_address_out1, bus_data_out0, bus_data_out1,
           cache_hit_out0, cache_hit_out1, flush_out0, flush_out1,
           mem_rdata, mem_ready,
    input  grant0, grant1, bus_operation_in0, bus_operation_in1,
           bus_address_in0, bus_address_in1, bus_data_in0, bus_data_in1,
           cache_hit_in0, cache_hit_in1, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_core0, req_core1, bus_operation_out0, bus_operation_out1,
           bus_address_out0, bus_address_out1, bus_data_out0, bus_data_out1,
           cache_hit_out0, cache_hit_out1, flush_out0, flush_out1,
           mem_rdata, mem_ready,
    output grant0, grant1, bus_operation_in0, bus_operation_in1,
           bus_address_in0, bus_address_in1, bus_data_in0, bus_data_in1,
           cache_hit_in0, cache_hit_in1, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
// Two-core snooping-bus interconnect. It grants the bus round-robin and
// forwards the owner's transaction to the other core as a snoop. It then
// collects the snoop response, performs a memory read or write-back when one
// is needed, and returns data and hit status to the owner.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : snoop_bus_arbiter_if.slave (core ports 0/1 and memory port)
// Every output is a register.
module snoop_bus_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  snoop_bus_arbiter_if.slave bus
);
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_NON  = 2'b11;
  localparam int CNT_W = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_SNOOP = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic              owner_r;
  logic              last_owner_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] resp_data_r;
  logic              hit_r;
  logic              flush_r;
  logic              grant0_r, grant1_r;
  logic [1:0]        bus_op_in0_r, bus_op_in1_r;
  logic [ADDR_W-1:0] bus_addr_in0_r, bus_addr_in1_r;
  logic [DATA_W-1:0] bus_data_in0_r, bus_data_in1_r;
  logic              cache_hit_in0_r, cache_hit_in1_r;
  logic              mem_req_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              req_own_s;
  logic [1:0]        op_own_s;
  logic [ADDR_W-1:0] addr_own_s;
  logic [DATA_W-1:0] data_own_s;
  logic              hit_snp_s;
  logic              flush_snp_s;
  logic [DATA_W-1:0] data_snp_s;
  logic              sel_s;

  assign bus.grant0            = grant0_r;
  assign bus.grant1            = grant1_r;
  assign bus.bus_operation_in0 = bus_op_in0_r;
  assign bus.bus_operation_in1 = bus_op_in1_r;
  assign bus.bus_address_in0   = bus_addr_in0_r;
  assign bus.bus_address_in1   = bus_addr_in1_r;
  assign bus.bus_data_in0      = bus_data_in0_r;
  assign bus.bus_data_in1      = bus_data_in1_r;
  assign bus.cache_hit_in0     = cache_hit_in0_r;
  assign bus.cache_hit_in1     = cache_hit_in1_r;
  assign bus.mem_req           = mem_req_r;
  assign bus.mem_we            = mem_we_r;
  assign bus.mem_addr          = mem_addr_r;
  assign bus.mem_wdata         = mem_wdata_r;

  // Owner-side and snooper-side views of the core ports, picked by owner_r.
  always_comb begin
    req_own_s   = 1'b0;
    op_own_s    = OP_NON;
    addr_own_s  = {ADDR_W{1'b0}};
    data_own_s  = {DATA_W{1'b0}};
    hit_snp_s   = 1'b0;
    flush_snp_s = 1'b0;
    data_snp_s  = {DATA_W{1'b0}};
    if (owner_r == 1'b0) begin
      req_own_s   = bus.req_core0;
      op_own_s    = bus.bus_operation_out0;
      addr_own_s  = bus.bus_address_out0;
      data_own_s  = bus.bus_data_out0;
      hit_snp_s   = bus.cache_hit_out1;
      flush_snp_s = bus.flush_out1;
      data_snp_s  = bus.bus_data_out1;
    end else begin
      req_own_s   = bus.req_core1;
      op_own_s    = bus.bus_operation_out1;
      addr_own_s  = bus.bus_address_out1;
      data_own_s  = bus.bus_data_out1;
      hit_snp_s   = bus.cache_hit_out0;
      flush_snp_s = bus.flush_out0;
      data_snp_s  = bus.bus_data_out0;
    end
  end

  // Round-robin pick in IDLE: on a tie the previous owner yields.
  always_comb begin
    sel_s = 1'b0;
    if (bus.req_core0 && bus.req_core1) begin
      sel_s = ~last_owner_r;
    end else if (bus.req_core1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Transaction FSM together with every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      owner_r         <= 1'b0;
      last_owner_r    <= 1'b1;
      cnt_r           <= {CNT_W{1'b0}};
      op_r            <= OP_NON;
      addr_r          <= {ADDR_W{1'b0}};
      data_r          <= {DATA_W{1'b0}};
      resp_data_r     <= {DATA_W{1'b0}};
      hit_r           <= 1'b0;
      flush_r         <= 1'b0;
      grant0_r        <= 1'b0;
      grant1_r        <= 1'b0;
      bus_op_in0_r    <= OP_NON;
      bus_op_in1_r    <= OP_NON;
      bus_addr_in0_r  <= {ADDR_W{1'b0}};
      bus_addr_in1_r  <= {ADDR_W{1'b0}};
      bus_data_in0_r  <= {DATA_W{1'b0}};
      bus_data_in1_r  <= {DATA_W{1'b0}};
      cache_hit_in0_r <= 1'b0;
      cache_hit_in1_r <= 1'b0;
      mem_req_r       <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_addr_r      <= {ADDR_W{1'b0}};
      mem_wdata_r     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_core0 || bus.req_core1) begin
            owner_r  <= sel_s;
            grant0_r <= ~sel_s;
            grant1_r <= sel_s;
            state_r  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A withdrawn request takes priority over an op issued in the same cycle.
          if (!req_own_s) begin
            grant0_r     <= 1'b0;
            grant1_r     <= 1'b0;
            last_owner_r <= owner_r;
            state_r      <= ST_IDLE;
          end else if (op_own_s != OP_NON) begin
            op_r        <= op_own_s;
            addr_r      <= addr_own_s;
            data_r      <= data_own_s;
            resp_data_r <= {DATA_W{1'b0}};
            hit_r       <= 1'b0;
            flush_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            // Only the snooper sees the operation; the owner stays at BusNoN.
            if (owner_r) begin
              bus_op_in0_r   <= op_own_s;
              bus_addr_in0_r <= addr_own_s;
              bus_data_in0_r <= data_own_s;
            end else begin
              bus_op_in1_r   <= op_own_s;
              bus_addr_in1_r <= addr_own_s;
              bus_data_in1_r <= data_own_s;
            end
            state_r <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          if (cnt_r == CNT_LAST) begin
            hit_r        <= hit_snp_s;
            flush_r      <= flush_snp_s;
            bus_op_in0_r <= OP_NON;
            bus_op_in1_r <= OP_NON;
            if (flush_snp_s) begin
              resp_data_r <= data_snp_s;
            end
            if (op_r == OP_UPGR) begin
              // Upgrade needs no data movement: answer the owner directly.
              if (owner_r) begin
                bus_data_in1_r  <= flush_snp_s ? data_snp_s : resp_data_r;
                bus_addr_in1_r  <= addr_r;
                cache_hit_in1_r <= hit_snp_s;
              end else begin
                bus_data_in0_r  <= flush_snp_s ? data_snp_s : resp_data_r;
                bus_addr_in0_r  <= addr_r;
                cache_hit_in0_r <= hit_snp_s;
              end
              state_r <= ST_DONE;
            end else begin
              // A flushed modified line is written back; otherwise fetch it.
              mem_req_r   <= 1'b1;
              mem_we_r    <= flush_snp_s;
              mem_addr_r  <= addr_r;
              mem_wdata_r <= flush_snp_s ? data_snp_s : {DATA_W{1'b0}};
              state_r     <= ST_MEM;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            if (!flush_r) begin
              resp_data_r <= bus.mem_rdata;
            end
            if (owner_r) begin
              bus_data_in1_r  <= flush_r ? resp_data_r : bus.mem_rdata;
              bus_addr_in1_r  <= addr_r;
              cache_hit_in1_r <= hit_r;
            end else begin
              bus_data_in0_r  <= flush_r ? resp_data_r : bus.mem_rdata;
              bus_addr_in0_r  <= addr_r;
              cache_hit_in0_r <= hit_r;
            end
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!req_own_s) begin
            grant0_r        <= 1'b0;
            grant1_r        <= 1'b0;
            cache_hit_in0_r <= 1'b0;
            cache_hit_in1_r <= 1'b0;
            last_owner_r    <= owner_r;
            state_r         <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
